// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
// Lock FSM states exist in every build; they are only used when DATA_MEM_ARB_LOCK_EN is defined.
package data_mem_arb_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// rtl/data_mem_arbiter_rr_pick2.sv - combinational two-way round-robin pick
// last = 1 means port 1 won most recently, so port 0 takes a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win    = 2'b00;
        win[0] = req[0] & (~req[1] | last);
        win[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one data memory between core and DMA
// Optional ownership lock for read-modify-write sequences is built with DATA_MEM_ARB_LOCK_EN.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [31:0]   mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    localparam int PADW = 32 - AW;

    logic [1:0]    win;
    logic          own0, own1;
    logic          acc0, acc1;
    logic          rd0, rd1;
    logic          last_q, last_d;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    rr_pick2 u_pick (
        .req  ({req1, req0}),
        .last (last_q),
        .win  (win)
    );

`ifdef DATA_MEM_ARB_LOCK_EN
    arb_state_e state_q, state_d;

    // An owner that stops requesting releases the memory in that same cycle.
    assign own0 = (state_q == ARB_OWN0) & req0;
    assign own1 = (state_q == ARB_OWN1) & req1;

    always_comb begin
        state_d = ARB_IDLE;
        if (acc0) begin
            state_d = lock0 ? ARB_OWN0 : ARB_IDLE;
        end else if (acc1) begin
            state_d = lock1 ? ARB_OWN1 : ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
    assign own0 = 1'b0;
    assign own1 = 1'b0;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (own0) begin
            gnt0 = 1'b1;
        end else if (own1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = win[PORT_CORE];
            gnt1 = win[PORT_DMA];
        end
    end

    assign acc0 = req0 & gnt0;
    assign acc1 = req1 & gnt1;
    assign rd0  = acc0 & ~we0;
    assign rd1  = acc1 & ~we1;

    always_comb begin
        mem_a  = 32'd0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (acc0) begin
            mem_a  = {{PADW{1'b0}}, addr0};
            mem_wd = wdata0;
            mem_we = we0;
        end else if (acc1) begin
            mem_a  = {{PADW{1'b0}}, addr1};
            mem_wd = wdata1;
            mem_we = we1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (acc1) begin
            last_d = 1'b1;
        end else if (acc0) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            if (rd0) begin
                rdata0_q <= mem_rd;
            end
            if (rd1) begin
                rdata1_q <= mem_rd;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed scoreboard bench for data_mem_arbiter
// Lock scenarios are exercised when DATA_MEM_ARB_LOCK_EN is defined.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          vectors;
    int          miscompares;

    data_mem_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .lock0  (lock0),
        .lock1  (lock1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_we (mem_we),
        .mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:0]] <= mem_wd;
    end
    assign mem_rd = mem_we ? 32'd0 : mem[mem_a[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input int port, input logic [31:0] obs);
        if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed %h expected <none queued>", tag, obs);
        end else if (port == 0) begin
            check(tag, obs, q0.pop_front());
        end else begin
            check(tag, obs, q1.pop_front());
        end
    endtask

    // Called one step after a rising edge with inputs already driven.
    task automatic cycle(input logic eg0, input logic eg1);
        logic p0, p1;
        #1;
        check("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        check("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        p0 = eg0 & req0 & ~we0;
        p1 = eg1 & req1 & ~we1;
        @(posedge clk);
        #1;
        check("rvalid0", {31'd0, rvalid0}, {31'd0, p0});
        check("rvalid1", {31'd0, rvalid1}, {31'd0, p1});
        if (p0) pop_check("rdata0", 0, rdata0);
        if (p1) pop_check("rdata1", 1, rdata1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0000_0010;
        mem[2] = 32'h0000_0022;

        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 10'd0; addr1 = 10'd1;
        wdata0 = 32'd0; wdata1 = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        reset = 1'b1;

        // Continuous contention: grants alternate starting with port 0.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                q0.push_back(32'h0000_0001);
                cycle(1'b1, 1'b0);
            end else begin
                q1.push_back(32'h0000_0010);
                cycle(1'b0, 1'b1);
            end
        end

        // Write from port 0, read it back on port 1 the next cycle.
        req1 = 1'b0;
        we0 = 1'b1; addr0 = 10'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_a", mem_a, 32'd5);
        check("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b0);
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; addr1 = 10'd5;
        q1.push_back(32'hDEAD_BEEF);
        cycle(1'b0, 1'b1);
        req1 = 1'b0;
        #1;
        check("idle_mem_a", mem_a, 32'd0);
        check("idle_mem_wd", mem_wd, 32'd0);
        check("idle_mem_we", {31'd0, mem_we}, 32'd0);
        cycle(1'b0, 1'b0);
        check("rdata1_hold", rdata1, 32'hDEAD_BEEF);

`ifdef DATA_MEM_ARB_LOCK_EN
        // Port 1 read-modify-write under lock while port 0 keeps requesting.
        req0 = 1'b1; addr0 = 10'd0;
        req1 = 1'b1; addr1 = 10'd2; lock1 = 1'b1;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        q1.push_back(32'h0000_0022);
        cycle(1'b0, 1'b1);
        we1 = 1'b1; wdata1 = 32'h0000_0101; lock1 = 1'b0;
        cycle(1'b0, 1'b1);
        req1 = 1'b0; we1 = 1'b0;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);

        // Port 0 locks, holds against a waiting port 1, then drops its request.
        lock0 = 1'b1;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        req1 = 1'b1; addr1 = 10'd2;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        req0 = 1'b0;
        q1.push_back(32'h0000_0101);
        cycle(1'b0, 1'b1);
        req0 = 1'b1; lock0 = 1'b0;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
`else
        // Lock requests are ignored: plain alternation continues.
        req0 = 1'b1; addr0 = 10'd0;
        req1 = 1'b1; addr1 = 10'd2; lock1 = 1'b1;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        q1.push_back(32'h0000_0022);
        cycle(1'b0, 1'b1);
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
`endif

        // Reset pulse while port 1 owns the memory and its read response is pending.
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd2; lock1 = 1'b1;
`ifdef DATA_MEM_ARB_LOCK_EN
        q1.push_back(32'h0000_0101);
`else
        q1.push_back(32'h0000_0022);
`endif
        cycle(1'b0, 1'b1);
        reset = 1'b0;
        req1 = 1'b0; lock1 = 1'b0;
        #1;
        check("rstpulse_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("rstpulse_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0 = 1'b1; addr0 = 10'd0;
        req1 = 1'b1; addr1 = 10'd1;
        q0.push_back(32'h0000_0001);
        cycle(1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        cycle(1'b0, 1'b0);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
